// File: rtl/cache_refill_responder_if.sv
// Refill bus between the I-cache controller and the memory-side responder,
// including the word-wide synchronous SRAM read port.
interface cache_refill_responder_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
);
  logic                                 mem_req;
  logic [ADDR_WIDTH-1:0]                mem_addr;
  logic                                 mem_ready;
  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] mem_line;
  logic                                 busy;
  logic                                 sram_en;
  logic [ADDR_WIDTH-1:0]                sram_addr;
  logic [WORD_WIDTH-1:0]                sram_rdata;

  modport master (
    output mem_req, mem_addr, sram_rdata,
    input  mem_ready, mem_line, busy, sram_en, sram_addr
  );

  modport slave (
    input  mem_req, mem_addr, sram_rdata,
    output mem_ready, mem_line, busy, sram_en, sram_addr
  );
endinterface

// File: rtl/cache_refill_responder.sv
// Memory-side I-cache refill responder: fixed wait states, then one SRAM read per
// beat, assembling a full line that is returned with a single-cycle mem_ready.
module cache_refill_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int WAIT_CYCLES    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  cache_refill_responder_if.slave  bus
);
  localparam int BYTES       = WORD_WIDTH / 8;
  localparam int OFFSET_BITS = $clog2(WORDS_PER_LINE * BYTES);
  localparam int LINE_W      = WORD_WIDTH * WORDS_PER_LINE;
  localparam int CNT_W       = $clog2(WORDS_PER_LINE + 1);
  localparam int WAIT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0]  NUM_WORDS = CNT_W'(WORDS_PER_LINE);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_RESP} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] base;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      cap_cnt;
  logic                  vld_p1;
  logic [LINE_W-1:0]     line;
  logic                  sram_en;
  logic                  mem_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    sram_en    = 1'b0;
    mem_ready  = 1'b0;
    case (state)
      S_IDLE: if (bus.mem_req) state_next = (WAIT_CYCLES == 0) ? S_READ : S_WAIT;
      S_WAIT: if (wait_cnt == WAIT_LAST) state_next = S_READ;
      S_READ: begin
        // Issue until every beat is out; the cycle after the last issue only captures.
        sram_en = (issue_cnt != NUM_WORDS);
        if (vld_p1 && (cap_cnt == LAST_WORD)) state_next = S_RESP;
      end
      S_RESP: begin
        mem_ready  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Stage p0: issue address; stage p1: SRAM data returns and lands in its word slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      base      <= '0;
      wait_cnt  <= '0;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      vld_p1    <= 1'b0;
      line      <= '0;
    end else begin
      vld_p1 <= sram_en;
      case (state)
        S_IDLE: begin
          if (bus.mem_req) begin
            base      <= {bus.mem_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            wait_cnt  <= '0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
          end
        end
        S_WAIT: wait_cnt <= wait_cnt + WAIT_W'(1);
        S_READ: begin
          if (sram_en) issue_cnt <= issue_cnt + CNT_W'(1);
          if (vld_p1) begin
            cap_cnt <= cap_cnt + CNT_W'(1);
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
              if (cap_cnt == CNT_W'(k)) line[k*WORD_WIDTH +: WORD_WIDTH] <= bus.sram_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Aligned base plus beat offset never carries out of the line, so the top line cannot wrap.
  assign bus.sram_addr = sram_en ? (base + ADDR_WIDTH'(issue_cnt) * ADDR_WIDTH'(BYTES)) : '0;
  assign bus.sram_en   = sram_en;
  assign bus.mem_ready = mem_ready;
  assign bus.mem_line  = line;
  assign bus.busy      = (state != S_IDLE);
endmodule
